stopwatch_input_ctrl: RTL and testbench



---
 rtl/stopwatch_pkg.sv | 18 +
 rtl/stopwatch_input_ctrl_db_fsm.sv | 95 +++++++++
 rtl/stopwatch_input_ctrl.sv | 100 ++++++++++
 tb/tb_stopwatch_input_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch input control stage.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    DB_ZERO  = 2'd0,
    DB_WAIT1 = 2'd1,
    DB_ONE   = 2'd2,
    DB_WAIT0 = 2'd3
  } db_state_t;

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } run_state_t;

  localparam int unsigned DB_CYCLES_DEFAULT = 32'd2_000_000;

endpackage

// File: rtl/stopwatch_input_ctrl_db_fsm.sv
// Two-flop synchroniser plus four-state debouncer for one raw board input.
// Outputs the debounced level and a one-cycle tick on its rising edge.
module db_fsm
  import stopwatch_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  // WAIT states spend DB_CYCLES edges before the level flips, so load one less.
  localparam logic [CW-1:0] LOAD = CW'(DB_CYCLES - 1);

  logic          sync_meta_r;
  logic          sync_r;
  db_state_t     state_r;
  db_state_t     state_next_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_next_s;
  logic          level_s;
  logic          level_prev_r;

  // Synchroniser, debounce state/counter and previous-level registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_meta_r  <= 1'b0;
      sync_r       <= 1'b0;
      state_r      <= DB_ZERO;
      cnt_r        <= {CW{1'b0}};
      level_prev_r <= 1'b0;
    end else begin
      sync_meta_r  <= raw;
      sync_r       <= sync_meta_r;
      state_r      <= state_next_s;
      cnt_r        <= cnt_next_s;
      level_prev_r <= level_s;
    end
  end

  // Debounce next-state and counter logic.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      DB_ZERO: begin
        if (sync_r) begin
          state_next_s = DB_WAIT1;
          cnt_next_s   = LOAD;
        end else begin
          state_next_s = DB_ZERO;
        end
      end
      DB_WAIT1: begin
        if (!sync_r) begin
          state_next_s = DB_ZERO;
        end else if (cnt_r == {CW{1'b0}}) begin
          state_next_s = DB_ONE;
        end else begin
          cnt_next_s = cnt_r - CW'(1'b1);
        end
      end
      DB_ONE: begin
        if (!sync_r) begin
          state_next_s = DB_WAIT0;
          cnt_next_s   = LOAD;
        end else begin
          state_next_s = DB_ONE;
        end
      end
      DB_WAIT0: begin
        if (sync_r) begin
          state_next_s = DB_ONE;
        end else if (cnt_r == {CW{1'b0}}) begin
          state_next_s = DB_ZERO;
        end else begin
          cnt_next_s = cnt_r - CW'(1'b1);
        end
      end
      default: begin
        state_next_s = DB_ZERO;
        cnt_next_s   = {CW{1'b0}};
      end
    endcase
  end

  assign level_s = (state_r == DB_ONE) || (state_r == DB_WAIT0);
  assign level   = level_s;
  assign rise    = level_s & ~level_prev_r;

endmodule

// File: rtl/stopwatch_input_ctrl.sv
// Stopwatch front end: debounced start/stop toggle, clear pulse and direction level.
// Optional macro STOPWATCH_DIR_LOCK_EN freezes direction while the counter runs.
module stopwatch_input_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_go,
  input  logic btn_clr,
  input  logic sw_dir,
  output logic go,
  output logic clr,
  output logic direction
);

  logic       go_level_s;
  logic       go_tick_s;
  logic       clr_level_s;
  logic       clr_tick_s;
  logic       dir_level_s;
  logic       dir_rise_s;
  logic       unused_s;
  run_state_t run_state_r;
  run_state_t run_next_s;
  logic       clr_r;
  logic       clr_next_s;
  logic       dir_r;

  db_fsm #(.DB_CYCLES(DB_CYCLES)) u_db_go (
    .clk(clk), .reset_n(reset_n), .raw(btn_go), .level(go_level_s), .rise(go_tick_s)
  );

  db_fsm #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
    .clk(clk), .reset_n(reset_n), .raw(btn_clr), .level(clr_level_s), .rise(clr_tick_s)
  );

  db_fsm #(.DB_CYCLES(DB_CYCLES)) u_db_dir (
    .clk(clk), .reset_n(reset_n), .raw(sw_dir), .level(dir_level_s), .rise(dir_rise_s)
  );

  assign unused_s = go_level_s ^ clr_level_s ^ dir_rise_s;

  // Run state and clear pulse registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      run_state_r <= STOPPED;
      clr_r       <= 1'b0;
    end else begin
      run_state_r <= run_next_s;
      clr_r       <= clr_next_s;
    end
  end

  // Clear has priority over a simultaneous start/stop toggle.
  always_comb begin
    run_next_s = run_state_r;
    clr_next_s = 1'b0;
    if (clr_tick_s) begin
      run_next_s = STOPPED;
      clr_next_s = 1'b1;
    end else if (go_tick_s) begin
      case (run_state_r)
        STOPPED: run_next_s = RUNNING;
        RUNNING: run_next_s = STOPPED;
        default: run_next_s = STOPPED;
      endcase
    end else begin
      run_next_s = run_state_r;
    end
  end

`ifdef STOPWATCH_DIR_LOCK_EN
  // Direction register; a change made while running stays pending in the debouncer.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dir_r <= 1'b0;
    end else if (run_state_r == STOPPED) begin
      dir_r <= dir_level_s;
    end else begin
      dir_r <= dir_r;
    end
  end
`else
  // Direction register tracking the debounced switch.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dir_r <= 1'b0;
    end else begin
      dir_r <= dir_level_s;
    end
  end
`endif

  assign go        = (run_state_r == RUNNING);
  assign clr       = clr_r;
  assign direction = dir_r;

endmodule

// File: tb/tb_stopwatch_input_ctrl.sv
// Directed self-checking bench for stopwatch_input_ctrl with DB_CYCLES=4 (latency 8).
module tb_stopwatch_input_ctrl;

  localparam int DB = 4;
  localparam int LAT = DB + 4;

  logic clk;
  logic reset_n;
  logic btn_go;
  logic btn_clr;
  logic sw_dir;
  logic go;
  logic clr;
  logic direction;

  int checks = 0;
  int errors = 0;
  int clr_cnt = 0;
  int go_hi_cnt = 0;
  int n;
  int c0;

  stopwatch_input_ctrl #(.DB_CYCLES(DB)) dut (
    .clk(clk), .reset_n(reset_n), .btn_go(btn_go), .btn_clr(btn_clr),
    .sw_dir(sw_dir), .go(go), .clr(clr), .direction(direction)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (clr === 1'b1) clr_cnt <= clr_cnt + 1;
    if (go === 1'b1) go_hi_cnt <= go_hi_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic sel(input int which);
    case (which)
      0: sel = go;
      1: sel = clr;
      default: sel = direction;
    endcase
  endfunction

  // Cycles until the selected output reaches val; -1 if the budget expires.
  task automatic wait_sig(input int which, input logic val, input int limit, output int cnt);
    cnt = -1;
    for (int i = 1; i <= limit; i++) begin
      step();
      if (sel(which) === val) begin
        cnt = i;
        break;
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; btn_go = 1'b0; btn_clr = 1'b0; sw_dir = 1'b0;
    steps(3);
    chk("reset_go", go, 0);
    chk("reset_clr", clr, 0);
    chk("reset_dir", direction, 0);
    reset_n = 1'b1;
    steps(2);

    // Hold btn_go: single toggle after exactly LAT cycles, no clear.
    c0 = clr_cnt;
    btn_go = 1'b1;
    wait_sig(0, 1'b1, 20, n);
    chk("t1_go_latency", n, LAT);
    steps(12);
    chk("t1_go_held", go, 1);
    chk("t1_no_clr", clr_cnt - c0, 0);
    btn_go = 1'b0;
    steps(12);
    btn_go = 1'b1;
    wait_sig(0, 1'b0, 20, n);
    chk("t1_go_stop_latency", n, LAT);
    btn_go = 1'b0;
    steps(12);

    // Short bounces never pass the debouncer.
    c0 = go_hi_cnt;
    for (int r = 0; r < 10; r++) begin
      btn_go = 1'b1; steps(3);
      btn_go = 1'b0; steps(3);
    end
    steps(4);
    chk("t2_glitch_go_low", go_hi_cnt - c0, 0);
    btn_go = 1'b1;
    wait_sig(0, 1'b1, 20, n);
    chk("t2_clean_press", n, LAT);

    // Clear while running (btn_go still held).
    c0 = clr_cnt;
    btn_clr = 1'b1;
    wait_sig(1, 1'b1, 20, n);
    chk("t3_clr_latency", n, LAT);
    chk("t3_go_with_clr", go, 0);
    steps(2);
    btn_clr = 1'b0;
    btn_go = 1'b0;
    steps(12);
    chk("t3_clr_once", clr_cnt - c0, 1);
    chk("t3_go_stays_low", go, 0);

    // Simultaneous go and clr from STOPPED.
    c0 = clr_cnt;
    btn_go = 1'b1; btn_clr = 1'b1;
    wait_sig(1, 1'b1, 20, n);
    chk("t4s_clr_latency", n, LAT);
    chk("t4s_go", go, 0);
    steps(12);
    chk("t4s_clr_once", clr_cnt - c0, 1);
    btn_go = 1'b0; btn_clr = 1'b0;
    steps(12);

    // Simultaneous go and clr from RUNNING.
    btn_go = 1'b1;
    wait_sig(0, 1'b1, 20, n);
    chk("t4r_start", n, LAT);
    btn_go = 1'b0;
    steps(12);
    c0 = clr_cnt;
    btn_go = 1'b1; btn_clr = 1'b1;
    wait_sig(1, 1'b1, 20, n);
    chk("t4r_clr_latency", n, LAT);
    chk("t4r_go", go, 0);
    steps(12);
    chk("t4r_clr_once", clr_cnt - c0, 1);
    btn_go = 1'b0; btn_clr = 1'b0;
    steps(12);

    // Direction change while running.
    btn_go = 1'b1;
    wait_sig(0, 1'b1, 20, n);
    chk("t5_start", n, LAT);
    btn_go = 1'b0;
    steps(12);
    sw_dir = 1'b1;
`ifdef STOPWATCH_DIR_LOCK_EN
    steps(12);
    chk("t5_dir_locked", direction, 0);
    btn_go = 1'b1;
    wait_sig(0, 1'b0, 20, n);
    chk("t5_stop", n, LAT);
    chk("t5_dir_still_locked", direction, 0);
    step();
    chk("t5_dir_applied", direction, 1);
`else
    wait_sig(2, 1'b1, 20, n);
    chk("t5_dir_latency", n, LAT);
    chk("t5_go_unaffected", go, 1);
    btn_go = 1'b1;
    wait_sig(0, 1'b0, 20, n);
    chk("t5_stop", n, LAT);
`endif
    btn_go = 1'b0;
    steps(12);

    // Reset mid-WAIT1 while running; held button must re-debounce.
    btn_go = 1'b1;
    wait_sig(0, 1'b1, 20, n);
    chk("t6_start", n, LAT);
    btn_go = 1'b0;
    steps(12);
    btn_go = 1'b1;
    steps(4);
    reset_n = 1'b0;
    step();
    chk("t6_rst_go", go, 0);
    chk("t6_rst_clr", clr, 0);
    chk("t6_rst_dir", direction, 0);
    reset_n = 1'b1;
    wait_sig(0, 1'b1, 20, n);
    chk("t6_redebounce", n, LAT);
    chk("t6_dir_restored", direction, 1);
    btn_go = 1'b0;
    steps(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
